// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the 3-stage RISC-V pipeline: sequencing states,
// major opcode constants and small decode helpers.
package rv_pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_OP_IMM = 5'b00100;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    BR_FLUSH = 2'd2,
    MEM_WAIT = 2'd3
  } pipe_state_e;

  // True when a destination register feeds either source operand.
  function automatic logic reg_match(input logic [4:0] rd,
                                     input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return (rd == rs1) | (rd == rs2);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for debug event statistics; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             srst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;

  // Count events, holding at the maximum instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (srst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch redirect and
// flush, data-memory freeze, and saturating stall/flush debug counters.
module pipe_hazard_ctrl #(
  parameter int XLEN         = rv_pipe_pkg::XLEN,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd_addr,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_target,
  input  logic             mem_busy,
  output logic             stall,
  output logic             condn_flag,
  output logic [XLEN-1:0]  adder,
  output logic             flush_id,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import rv_pipe_pkg::*;

  localparam logic [1:0] FLUSH_LEFT = 2'(FLUSH_CYCLES - 1);

  pipe_state_e     state_r, state_nx_s, ret_state_r, ret_nx_s, cur_s;
  logic [1:0]      left_r, left_nx_s;
  logic            stall_q_r, stall_q_nx_s;
  logic            condn_r, condn_nx_s;
  logic            flush_r, flush_nx_s;
  logic            pend_r, pend_nx_s;
  logic [XLEN-1:0] adder_r, adder_nx_s;
  logic [XLEN-1:0] pend_tgt_r, pend_tgt_nx_s;
  logic [XLEN-1:0] redir_tgt_s;
  logic            load_use_s, br_hit_s, redirect_s;
  logic            stall_s, flush_inc_s;

  // Effective sequencing state (frozen one while waiting) and hazard terms
  always_comb begin
    if (state_r == MEM_WAIT) begin
      cur_s = ret_state_r;
    end else begin
      cur_s = state_r;
    end
    load_use_s = id_valid & ex_valid & ex_is_load & (ex_rd_addr != 5'd0)
               & reg_match(ex_rd_addr, id_rs1_addr, id_rs2_addr);
    br_hit_s   = ex_valid & br_taken;
    redirect_s = br_hit_s | pend_r;
    if (br_hit_s) begin
      redir_tgt_s = br_target;
    end else begin
      redir_tgt_s = pend_tgt_r;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nx_s    = state_r;
    ret_nx_s      = ret_state_r;
    left_nx_s     = left_r;
    stall_q_nx_s  = 1'b0;
    condn_nx_s    = 1'b0;
    flush_nx_s    = 1'b0;
    adder_nx_s    = adder_r;
    pend_nx_s     = pend_r;
    pend_tgt_nx_s = pend_tgt_r;

    if (mem_busy) begin
      state_nx_s   = MEM_WAIT;
      stall_q_nx_s = stall_q_r;
      flush_nx_s   = flush_r;
      if (condn_r) begin
        // Fetch was stalled while the redirect strobe was up: replay it later
        ret_nx_s      = RUN;
        left_nx_s     = 2'd0;
        pend_nx_s     = 1'b1;
        pend_tgt_nx_s = adder_r;
      end else if (br_hit_s && (cur_s != BR_FLUSH)) begin
        ret_nx_s      = cur_s;
        pend_nx_s     = 1'b1;
        pend_tgt_nx_s = br_target;
      end else begin
        ret_nx_s = cur_s;
      end
    end else begin
      case (cur_s)
        RUN, LD_STALL: begin
          if (redirect_s) begin
            state_nx_s = BR_FLUSH;
            condn_nx_s = 1'b1;
            flush_nx_s = 1'b1;
            adder_nx_s = redir_tgt_s;
            left_nx_s  = FLUSH_LEFT;
            pend_nx_s  = 1'b0;
          end else if (load_use_s && (cur_s == RUN)) begin
            state_nx_s   = LD_STALL;
            stall_q_nx_s = 1'b1;
            flush_nx_s   = 1'b1;
          end else begin
            state_nx_s = RUN;
          end
        end
        BR_FLUSH: begin
          if (left_r != 2'd0) begin
            state_nx_s = BR_FLUSH;
            flush_nx_s = 1'b1;
            left_nx_s  = left_r - 2'd1;
          end else begin
            state_nx_s = RUN;
          end
        end
        default: begin
          state_nx_s = RUN;
        end
      endcase
    end
  end

  // State and registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      ret_state_r <= RUN;
      left_r      <= 2'd0;
      stall_q_r   <= 1'b0;
      condn_r     <= 1'b0;
      flush_r     <= 1'b0;
      adder_r     <= {XLEN{1'b0}};
      pend_r      <= 1'b0;
      pend_tgt_r  <= {XLEN{1'b0}};
    end else begin
      state_r     <= state_nx_s;
      ret_state_r <= ret_nx_s;
      left_r      <= left_nx_s;
      stall_q_r   <= stall_q_nx_s;
      condn_r     <= condn_nx_s;
      flush_r     <= flush_nx_s;
      adder_r     <= adder_nx_s;
      pend_r      <= pend_nx_s;
      pend_tgt_r  <= pend_tgt_nx_s;
    end
  end

  // mem_busy must hold fetch in the very cycle it is raised
  assign stall_s     = stall_q_r | mem_busy;
  assign flush_inc_s = condn_r & ~mem_busy;

  assign stall      = stall_s;
  assign condn_flag = condn_r;
  assign adder      = adder_r;
  assign flush_id   = flush_r;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .srst  (1'b0),
    .inc   (stall_s),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .srst  (1'b0),
    .inc   (flush_inc_s),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with FLUSH_CYCLES=2 and 4-bit counters.
module tb_pipe_hazard_ctrl;

  localparam int XLEN = 32;
  localparam int FC   = 2;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [4:0]      id_rs1_addr, id_rs2_addr;
  logic            ex_valid, ex_is_load;
  logic [4:0]      ex_rd_addr;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            mem_busy;
  logic            stall, condn_flag, flush_id;
  logic [XLEN-1:0] adder;
  logic [CW-1:0]   stall_cnt, flush_cnt;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .ex_valid    (ex_valid),
    .ex_is_load  (ex_is_load),
    .ex_rd_addr  (ex_rd_addr),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .mem_busy    (mem_busy),
    .stall       (stall),
    .condn_flag  (condn_flag),
    .adder       (adder),
    .flush_id    (flush_id),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_in();
    id_valid    = 1'b0;
    id_rs1_addr = 5'd0;
    id_rs2_addr = 5'd0;
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    ex_rd_addr  = 5'd0;
    br_taken    = 1'b0;
    br_target   = 32'd0;
    mem_busy    = 1'b0;
  endtask

  task automatic do_reset();
    next_cyc();
    rst = 1'b1;
    clear_in();
    next_cyc();
    rst = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ex_valid    = 1'b1;
    ex_is_load  = 1'b1;
    ex_rd_addr  = rd;
    id_valid    = 1'b1;
    id_rs1_addr = rs1;
    id_rs2_addr = rs2;
  endtask

  task automatic set_branch(input logic [31:0] tgt);
    ex_valid  = 1'b1;
    br_taken  = 1'b1;
    br_target = tgt;
  endtask

  // Redirect and load stall must never meet unless mem_busy forces the stall
  always @(negedge clk) begin
    check_eq("cf_stall_excl", 32'(condn_flag & stall & ~mem_busy), 32'd0);
  end

  initial begin
    rst = 1'b1;
    clear_in();
    repeat (2) @(posedge clk);
    mid();
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_condn", 32'(condn_flag), 32'd0);
    check_eq("rst_flush", 32'(flush_id), 32'd0);
    check_eq("rst_adder", adder, 32'd0);
    check_eq("rst_scnt", 32'(stall_cnt), 32'd0);
    check_eq("rst_fcnt", 32'(flush_cnt), 32'd0);

    // Load-use on rs1, then rd=x0, then rs2 match
    do_reset();
    set_load(5'd14, 5'd14, 5'd0);
    mid();
    check_eq("ld_pre_stall", 32'(stall), 32'd0);
    next_cyc(); clear_in(); mid();
    check_eq("ld_stall", 32'(stall), 32'd1);
    check_eq("ld_flush", 32'(flush_id), 32'd1);
    check_eq("ld_condn", 32'(condn_flag), 32'd0);
    check_eq("ld_cnt0", 32'(stall_cnt), 32'd0);
    next_cyc(); mid();
    check_eq("ld_stall_end", 32'(stall), 32'd0);
    check_eq("ld_flush_end", 32'(flush_id), 32'd0);
    check_eq("ld_cnt1", 32'(stall_cnt), 32'd1);
    next_cyc(); set_load(5'd0, 5'd0, 5'd0); mid();
    next_cyc(); clear_in(); mid();
    check_eq("x0_stall", 32'(stall), 32'd0);
    check_eq("x0_flush", 32'(flush_id), 32'd0);
    next_cyc(); set_load(5'd7, 5'd3, 5'd7); mid();
    next_cyc(); clear_in(); mid();
    check_eq("rs2_stall", 32'(stall), 32'd1);
    next_cyc(); mid();
    check_eq("rs2_cnt", 32'(stall_cnt), 32'd2);

    // Taken branch with a two-cycle flush
    do_reset();
    set_branch(32'h18);
    mid();
    check_eq("br_pre_condn", 32'(condn_flag), 32'd0);
    next_cyc(); clear_in(); mid();
    check_eq("br_condn", 32'(condn_flag), 32'd1);
    check_eq("br_adder", adder, 32'h18);
    check_eq("br_flush1", 32'(flush_id), 32'd1);
    check_eq("br_stall", 32'(stall), 32'd0);
    check_eq("br_fcnt0", 32'(flush_cnt), 32'd0);
    next_cyc(); mid();
    check_eq("br_condn_off", 32'(condn_flag), 32'd0);
    check_eq("br_flush2", 32'(flush_id), 32'd1);
    check_eq("br_fcnt1", 32'(flush_cnt), 32'd1);
    next_cyc(); mid();
    check_eq("br_flush_end", 32'(flush_id), 32'd0);
    check_eq("br_fcnt_hold", 32'(flush_cnt), 32'd1);

    // Branch and load-use in the same cycle: branch wins
    do_reset();
    set_load(5'd5, 5'd5, 5'd0);
    set_branch(32'h40);
    mid();
    next_cyc(); clear_in(); mid();
    check_eq("bl_condn", 32'(condn_flag), 32'd1);
    check_eq("bl_adder", adder, 32'h40);
    check_eq("bl_stall", 32'(stall), 32'd0);
    next_cyc(); mid();
    check_eq("bl_stall2", 32'(stall), 32'd0);
    next_cyc(); mid();
    check_eq("bl_scnt", 32'(stall_cnt), 32'd0);

    // Branch under mem_busy, target overwritten while pending
    do_reset();
    set_branch(32'h80); mem_busy = 1'b1; mid();
    check_eq("mb1_stall", 32'(stall), 32'd1);
    check_eq("mb1_condn", 32'(condn_flag), 32'd0);
    next_cyc(); set_branch(32'h90); mid();
    check_eq("mb2_stall", 32'(stall), 32'd1);
    check_eq("mb2_condn", 32'(condn_flag), 32'd0);
    next_cyc(); ex_valid = 1'b0; br_taken = 1'b0; mid();
    check_eq("mb3_stall", 32'(stall), 32'd1);
    check_eq("mb3_condn", 32'(condn_flag), 32'd0);
    next_cyc(); clear_in(); mid();
    check_eq("mbf_stall", 32'(stall), 32'd0);
    check_eq("mbf_condn", 32'(condn_flag), 32'd0);
    check_eq("mbf_scnt", 32'(stall_cnt), 32'd3);
    next_cyc(); mid();
    check_eq("mbr_condn", 32'(condn_flag), 32'd1);
    check_eq("mbr_adder", adder, 32'h90);
    check_eq("mbr_flush", 32'(flush_id), 32'd1);
    check_eq("mbr_stall", 32'(stall), 32'd0);
    next_cyc(); mid();
    check_eq("mbr_condn_off", 32'(condn_flag), 32'd0);
    check_eq("mbr_fcnt", 32'(flush_cnt), 32'd1);

    // stall_cnt saturation at 15 over 20 busy cycles
    do_reset();
    mem_busy = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) next_cyc();
      mid();
      if (k == 15 || k == 16 || k == 20) begin
        check_eq($sformatf("sat_cnt_k%0d", k), 32'(stall_cnt), (k - 1 > 15) ? 32'd15 : 32'(k - 1));
      end
    end
    next_cyc(); mem_busy = 1'b0; mid();
    check_eq("sat_final", 32'(stall_cnt), 32'd15);
    check_eq("sat_stall_off", 32'(stall), 32'd0);

    // Asynchronous reset between edges during the flush sequence
    do_reset();
    set_branch(32'h18); mid();
    next_cyc(); clear_in(); mid();
    check_eq("ar_condn", 32'(condn_flag), 32'd1);
    next_cyc(); mid();
    check_eq("ar_flush_pre", 32'(flush_id), 32'd1);
    check_eq("ar_fcnt_pre", 32'(flush_cnt), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_flush", 32'(flush_id), 32'd0);
    check_eq("ar_condn0", 32'(condn_flag), 32'd0);
    check_eq("ar_adder", adder, 32'd0);
    check_eq("ar_fcnt", 32'(flush_cnt), 32'd0);
    check_eq("ar_scnt", 32'(stall_cnt), 32'd0);
    check_eq("ar_stall", 32'(stall), 32'd0);
    next_cyc(); rst = 1'b0;
    set_load(5'd9, 5'd9, 5'd0); mid();
    next_cyc(); clear_in(); mid();
    check_eq("ar_run_stall", 32'(stall), 32'd1);
    check_eq("ar_run_flush", 32'(flush_id), 32'd1);

    next_cyc();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
